// File: rtl/bus_mux2_1.sv
// Parameterized 2:1 bus mux leaf cell: combinational out plus a registered copy out_q.
// Define BUS_MUX2_1_STRUCT_EN to build out from gate primitives with 50 ps gate delays.
`timescale 1ns/10ps

module bus_mux2_1 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    logic [WIDTH-1:0] r_out_q;

`ifdef BUS_MUX2_1_STRUCT_EN
    wire             w_nsel;
    wire [WIDTH-1:0] w_and0;
    wire [WIDTH-1:0] w_and1;

    // One inverter is shared by every bit slice
    not #0.05 u_nsel (w_nsel, sel);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        and #0.05 u_and0 (w_and0[i], in0[i], w_nsel);
        and #0.05 u_and1 (w_and1[i], in1[i], sel);
        or  #0.05 u_or   (out[i], w_and0[i], w_and1[i]);
    end
`else
    assign out = sel ? in1 : in0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_out_q <= '0;
        else       r_out_q <= out;
    end

    assign out_q = r_out_q;

endmodule

// File: tb/tb_bus_mux2_1.sv
// Directed bench for bus_mux2_1: single cell, 4:1 tree of cells, and WIDTH=1/64 bitwise sweeps.
`timescale 1ns/10ps

module tb_bus_mux2_1;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in0, in1;
    logic        sel;
    logic [15:0] out, out_q;

    logic [1:0]  tsel;
    logic [15:0] t_lo, t_hi, t_out;
    logic [15:0] t_q0, t_q1, t_q2;
    logic        tie0 = 1'b0;

    logic        wsel;
    logic [0:0]  w1_in0, w1_in1, w1_out, w1_q;
    logic [63:0] w64_in0, w64_in1, w64_out, w64_q;

    always #5 clk = ~clk;

    bus_mux2_1 #(.WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .in0(in0), .in1(in1), .sel(sel), .out(out), .out_q(out_q)
    );

    bus_mux2_1 #(.WIDTH(16)) u_lo (
        .clk(tie0), .reset(tie0), .in0(16'h0123), .in1(16'h4567), .sel(tsel[0]), .out(t_lo), .out_q(t_q0)
    );
    bus_mux2_1 #(.WIDTH(16)) u_hi (
        .clk(tie0), .reset(tie0), .in0(16'h89AB), .in1(16'hCDEF), .sel(tsel[0]), .out(t_hi), .out_q(t_q1)
    );
    bus_mux2_1 #(.WIDTH(16)) u_root (
        .clk(tie0), .reset(tie0), .in0(t_lo), .in1(t_hi), .sel(tsel[1]), .out(t_out), .out_q(t_q2)
    );

    bus_mux2_1 #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .in0(w1_in0), .in1(w1_in1), .sel(wsel), .out(w1_out), .out_q(w1_q)
    );
    bus_mux2_1 #(.WIDTH(64)) u_w64 (
        .clk(clk), .reset(reset), .in0(w64_in0), .in1(w64_in1), .sel(wsel), .out(w64_out), .out_q(w64_q)
    );

    task automatic push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Leaves the bench 2 ns past a rising edge, well clear of the next one
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        in0 = 16'h0123; in1 = 16'h4567; sel = 1'b0;
        tsel = 2'd0; wsel = 1'b0;
        w1_in0 = 1'b0; w1_in1 = 1'b1;
        w64_in0 = '0; w64_in1 = '1;

        // Combinational select while reset is held
        push("comb_sel0", 64'h0123);
        #10 check({48'h0, out});
        sel = 1'b1;
        push("comb_sel1", 64'h4567);
        #10 check({48'h0, out});

        // Two reset edges clear out_q, out still tracks input
        in0 = 16'hFFFF; sel = 1'b0;
        tick(); tick();
        push("rst_out_q", 64'h0000);
        check({48'h0, out_q});
        push("rst_out", 64'hFFFF);
        check({48'h0, out});

        // Release reset: first edge captures out
        reset = 1'b0; in1 = 16'hCDEF; sel = 1'b1;
        tick();
        push("cap_in1", 64'hCDEF);
        check({48'h0, out_q});

        // Select flips between edges: out moves now, out_q on the next edge
        in0 = 16'h89AB; sel = 1'b0;
        #1;
        push("flip_out", 64'h89AB);
        check({48'h0, out});
        push("flip_hold_q", 64'hCDEF);
        check({48'h0, out_q});
        tick();
        push("flip_cap_q", 64'h89AB);
        check({48'h0, out_q});

        // Mid-operation reset
        sel = 1'b1;
        tick();
        push("pre_rst_q", 64'hCDEF);
        check({48'h0, out_q});
        reset = 1'b1;
        tick();
        push("mid_rst_q", 64'h0000);
        check({48'h0, out_q});
        tick();
        push("hold_rst_q", 64'h0000);
        check({48'h0, out_q});
        push("rst_out_tracks", 64'hCDEF);
        check({48'h0, out});
        reset = 1'b0; sel = 1'b0;
        tick();
        push("deassert_reload", 64'h89AB);
        check({48'h0, out_q});

        // Four-input tree with clk/reset tied low
        for (int s = 0; s < 4; s++) begin
            logic [15:0] tv [4];
            tv[0] = 16'h0123; tv[1] = 16'h4567; tv[2] = 16'h89AB; tv[3] = 16'hCDEF;
            tsel = s[1:0];
            push($sformatf("tree_sel%0d", s), {48'h0, tv[s]});
            #10 check({48'h0, t_out});
        end

        // Bitwise extremes at WIDTH=1 and WIDTH=64
        for (int k = 0; k < 4; k++) begin
            wsel = k[0];
            push($sformatf("w1_sel%0d", k), {63'h0, wsel});
            push($sformatf("w64_sel%0d", k), wsel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
            #10;
            check({63'h0, w1_out});
            check(w64_out);
        end

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
